// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM state type and default frame constants used by uart_tx, uart_baud_tick and the receiver
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_STOP_BITS = 1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; ports clk, rst_n (async active-low), restart (hold count at 0), tick (last cycle of a bit period)
module uart_baud_tick import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= restart || tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1-style UART transmitter with one-entry holding buffer; ports clk, rst_n (async active-low), in_data/in_valid/in_ready (byte handshake), tx (registered serial line, idle high), busy (frame in flight or buffer full)
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy
);
  localparam int BW = $clog2(DATA_BITS + 1);
  uart_state_e state, state_d;
  logic [DATA_BITS-1:0] buf_q, shift, shift_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic tick, buf_full, take, stop_done, load, tx_d;
  assign buf_full = !in_ready;
  assign take = in_valid && in_ready;
  assign busy = state != IDLE || buf_full;
  assign stop_done = state == STOP && tick && bit_cnt == BW'(STOP_BITS - 1);
  assign load = buf_full && (state == IDLE || stop_done);
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk(clk),
    .rst_n(rst_n),
    .restart(state == IDLE),
    .tick(tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      buf_q    <= '0;
      in_ready <= 1'b1;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      bit_cnt  <= bit_cnt_d;
      in_ready <= load || (in_ready && !in_valid);
      tx       <= tx_d;
      if (take) buf_q <= in_data;
    end
  always_comb
    state_d = load ? START :
              state == START && tick ? DATA :
              state == DATA && tick && bit_cnt == BW'(DATA_BITS - 1) ? STOP :
              stop_done ? IDLE : state;
  // tx is registered from the next-state view so the start bit appears on the load edge itself
  always_comb begin
    shift_d   = load ? buf_q : state == DATA && tick ? shift >> 1 : shift;
    bit_cnt_d = state_d != state ? '0 : tick && state != IDLE ? bit_cnt + 1'b1 : bit_cnt;
    tx_d      = state_d == DATA ? shift_d[0] : state_d != START;
  end
endmodule
